mips_bus_arbiter: RTL

Parametrised bus arbiter that multiplexes N_CH independent memory requesters onto the single Avalon-style memory bus of the MIPS CPU: address, read, write, writedata, byteenable, waitrequest, readdata. Typical requesters are instruction fetch, data load/store and debug. Arbitration is round-robin. Each transfer is held stable while waitrequest is high, and the result is returned to the granted channel as a one-cycle response. An optional timeout aborts stalled transfers with an error flag.

---
 rtl/mips_bus_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter that puts N_CH requesters onto one Avalon-style
// memory bus. It runs one transfer at a time, with an optional abort
// when the slave stalls for too long.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no transfer outstanding; grant is combinational from req_valid
//   S_BUS  | latched transfer on the bus, waiting for waitrequest low
module mips_bus_arbiter #(
  parameter int N_CH    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          req_valid,
  input  logic [N_CH-1:0]          req_write,
  input  logic [N_CH*AW-1:0]       req_addr,
  input  logic [N_CH*DW-1:0]       req_wdata,
  input  logic [N_CH*(DW/8)-1:0]   req_be,
  output logic [N_CH-1:0]          req_ready,
  output logic [N_CH-1:0]          rsp_valid,
  output logic [DW-1:0]            rsp_rdata,
  output logic                     rsp_err,
  output logic [AW-1:0]            address,
  output logic                     read,
  output logic                     write,
  output logic [DW-1:0]            writedata,
  output logic [DW/8-1:0]          byteenable,
  input  logic                     waitrequest,
  input  logic [DW-1:0]            readdata,
  output logic                     busy
);

  localparam int BE = DW / 8;
  localparam int LW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LW-1:0]   r_last;
  logic [LW-1:0]   r_gnt;
  logic            r_wr;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [BE-1:0]   r_be;
  logic [CW-1:0]   r_cnt;
  logic [N_CH-1:0] r_rsp_valid;
  logic            r_rsp_err;
  logic [DW-1:0]   r_rsp_rdata;

  logic            w_found;
  logic [LW-1:0]   w_win;
  logic [LW-1:0]   w_cand;
  int              w_t;
  logic            w_grant;
  logic            w_done;
  logic            w_abort;

  // Rotating-priority search starting just after the last granted channel.
  // With N_CH=1 this always lands on channel 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    w_t     = 0;
    for (int k = 1; k <= N_CH; k++) begin
      w_t = int'(r_last) + k;
      if (w_t >= N_CH) w_t = w_t - N_CH;
      w_cand = LW'(w_t);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_found;
  assign w_done  = (r_state == S_BUS) && !waitrequest;
  // The counter still runs when TIMEOUT is 0, but its compare is disabled.
  assign w_abort = (TIMEOUT > 0) && (r_state == S_BUS) && waitrequest &&
                   (r_cnt == CW'(TIMEOUT - 1));

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_BUS;
      S_BUS:   if (w_done || w_abort) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Latch the granted request, run the stall counter and form the one-cycle response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last      <= LW'(N_CH - 1);
      r_gnt       <= '0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      if (w_grant) begin
        r_gnt   <= w_win;
        r_last  <= w_win;
        r_wr    <= req_write[w_win];
        r_addr  <= req_addr[int'(w_win)*AW +: AW];
        r_wdata <= req_wdata[int'(w_win)*DW +: DW];
        r_be    <= req_be[int'(w_win)*BE +: BE];
        r_cnt   <= '0;
      end else if (w_done) begin
        r_rsp_valid <= N_CH'(1) << r_gnt;
        r_rsp_rdata <= r_wr ? '0 : readdata;
      end else if (w_abort) begin
        r_rsp_valid <= N_CH'(1) << r_gnt;
        r_rsp_err   <= 1'b1;
      end else if (r_state == S_BUS && waitrequest) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Grant is suppressed while reset is held so every output reads 0 in reset.
  assign req_ready  = (reset && w_grant) ? (N_CH'(1) << w_win) : '0;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_err    = r_rsp_err;
  assign rsp_rdata  = r_rsp_rdata;
  assign busy       = (r_state == S_BUS);
  assign read       = busy && !r_wr;
  assign write      = busy && r_wr;
  assign address    = r_addr;
  assign writedata  = busy ? r_wdata : '0;
  assign byteenable = busy ? r_be : '0;

endmodule
